// File: rtl/rf_scoreboard.sv
// Register file with pending scoreboard and soft-clear sequencer.
// Define RF_BYPASS_EN for write-to-read forwarding on both read ports.
module rf_scoreboard #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rbusy0,
  output logic              rbusy1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_rdy,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_ok;
  logic              iss_ok;

  assign clr_busy = (state_q == S_CLEAR);
  assign clr_done = (state_q == S_DONE);

  assign wr_ok   = we && (waddr != '0) && !clr_busy;
  assign iss_rdy = (iss_addr != '0) && !pend_q[iss_addr] && !clr_busy;
  assign iss_ok  = iss_en && iss_rdy;

`ifdef RF_BYPASS_EN
  logic byp0, byp1;
  assign byp0   = wr_ok && (waddr == raddr0);
  assign byp1   = wr_ok && (waddr == raddr1);
  assign rdata0 = byp0 ? wdata : mem_q[raddr0];
  assign rdata1 = byp1 ? wdata : mem_q[raddr1];
  assign rbusy0 = byp0 ? 1'b0 : pend_q[raddr0];
  assign rbusy1 = byp1 ? 1'b0 : pend_q[raddr1];
`else
  assign rdata0 = mem_q[raddr0];
  assign rdata1 = mem_q[raddr1];
  assign rbusy0 = pend_q[raddr0];
  assign rbusy1 = pend_q[raddr1];
`endif

  // Soft-clear sequencer: walk idx from 1 to DEPTH-1, then pulse done.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_CLEAR;
          idx_d   = ONE;
        end
      end
      S_CLEAR: begin
        if (idx_q == LAST) state_d = S_DONE;
        else               idx_d   = idx_q + ONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next file/scoreboard contents: writeback, then issue, then clear.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (wr_ok) begin
      mem_d[waddr]  = wdata;
      pend_d[waddr] = 1'b0;
    end
    if (iss_ok) pend_d[iss_addr] = 1'b1;
    if (clr_busy) begin
      mem_d[idx_q]  = '0;
      pend_d[idx_q] = 1'b0;
    end
    mem_d[0]  = '0;
    pend_d[0] = 1'b0;
  end

  // State registers; async reset also aborts a clear in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed testbench for rf_scoreboard.
// Covers reads, r0, issue/writeback, soft clear, reset abort and bypass.
module tb_rf_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr0, raddr1;
  logic [7:0] rdata0, rdata1;
  logic       rbusy0, rbusy1;
  logic       iss_en;
  logic [2:0] iss_addr;
  logic       iss_rdy;
  logic       clr_req;
  logic       clr_busy, clr_done;

  int total = 0;
  int bad   = 0;

  rf_scoreboard #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rbusy0(rbusy0), .rbusy1(rbusy1),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_rdy(iss_rdy),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] r0;
    logic [2:0] r1;
    logic       ie;
    logic [2:0] ia;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       eb0;
    logic       eb1;
    logic       erdy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    we = 0; waddr = 0; wdata = 0;
    iss_en = 0; iss_addr = 0; clr_req = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    idle_in();
    we = 1; waddr = a; wdata = d;
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < 8; a++) begin
      @(negedge clk);
      idle_in();
      raddr0 = 3'(a); raddr1 = 3'(7 - a);
      #1;
      chk({nm, "_rd0"}, rdata0, 0);
      chk({nm, "_rd1"}, rdata1, 0);
      chk({nm, "_bz0"}, rbusy0, 0);
      chk({nm, "_bz1"}, rbusy1, 0);
    end
  endtask

  int busy_n;
  int done_n;

  initial begin
    tbl[0]  = '{0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    tbl[1]  = '{0, 0, 8'h00, 2, 3, 0, 3, 8'h00, 8'h00, 0, 0, 1};
    tbl[2]  = '{0, 0, 8'h00, 4, 5, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    tbl[3]  = '{0, 0, 8'h00, 6, 7, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    tbl[4]  = '{1, 0, 8'hFF, 1, 2, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    tbl[5]  = '{0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
    tbl[6]  = '{0, 0, 8'h00, 0, 3, 1, 3, 8'h00, 8'h00, 0, 0, 1};
    tbl[7]  = '{0, 0, 8'h00, 3, 0, 1, 3, 8'h00, 8'h00, 1, 0, 0};
    tbl[8]  = '{1, 3, 8'h5A, 1, 2, 0, 0, 8'h00, 8'h00, 0, 0, 0};
    tbl[9]  = '{1, 5, 8'h11, 3, 0, 1, 5, 8'h5A, 8'h00, 0, 0, 1};
    tbl[10] = '{0, 0, 8'h00, 5, 3, 0, 5, 8'h11, 8'h5A, 1, 0, 0};
    tbl[11] = '{1, 5, 8'h22, 0, 3, 0, 0, 8'h00, 8'h5A, 0, 0, 0};
    tbl[12] = '{0, 0, 8'h00, 5, 5, 0, 5, 8'h22, 8'h22, 0, 0, 1};

    idle_in();
    raddr0 = 0; raddr1 = 0;
    rst = 1;
    #12;
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    @(negedge clk);
    rst = 0;

    read_all_zero("reset");

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      we = tbl[i].we; waddr = tbl[i].wa; wdata = tbl[i].wd;
      raddr0 = tbl[i].r0; raddr1 = tbl[i].r1;
      iss_en = tbl[i].ie; iss_addr = tbl[i].ia;
      clr_req = 0;
      #1;
      chk($sformatf("v%0d_rd0", i), rdata0, tbl[i].e0);
      chk($sformatf("v%0d_rd1", i), rdata1, tbl[i].e1);
      chk($sformatf("v%0d_bz0", i), rbusy0, tbl[i].eb0);
      chk($sformatf("v%0d_bz1", i), rbusy1, tbl[i].eb1);
      chk($sformatf("v%0d_rdy", i), iss_rdy, tbl[i].erdy);
    end

    // Soft clear with a dropped write and issue mid-sequence.
    for (int i = 1; i < 8; i++) wr(3'(i), 8'(i * 16));
    @(negedge clk);
    idle_in();
    iss_en = 1; iss_addr = 6;
    raddr0 = 6; raddr1 = 2;
    #1;
    chk("pre_clr_rdy", iss_rdy, 1);
    chk("pre_clr_r2", rdata1, 8'h20);
    @(negedge clk);
    idle_in();
    clr_req = 1;
    #1;
    chk("pre_clr_bz6", rbusy0, 1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      idle_in();
      raddr0 = 7; raddr1 = 1;
      if (c == 3) begin
        we = 1; waddr = 2; wdata = 8'hEE;
        iss_en = 1; iss_addr = 1;
      end
      #1;
      chk($sformatf("clr%0d_busy", c), clr_busy, 1);
      chk($sformatf("clr%0d_done", c), clr_done, 0);
      if (c == 0) chk("clr0_r7", rdata0, 8'h70);
      if (c == 3) chk("clr3_rdy", iss_rdy, 0);
    end
    @(negedge clk);
    idle_in();
    #1;
    chk("clr_end_busy", clr_busy, 0);
    chk("clr_end_done", clr_done, 1);
    @(negedge clk);
    #1;
    chk("clr_post_done", clr_done, 0);
    read_all_zero("after_clr");

    // Reset in the third CLEAR cycle aborts the sequence.
    wr(4, 8'h44);
    @(negedge clk);
    idle_in();
    iss_en = 1; iss_addr = 6;
    @(negedge clk);
    idle_in();
    clr_req = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_in();
    end
    @(negedge clk);
    idle_in();
    raddr0 = 4; raddr1 = 6;
    #1;
    chk("abort_pre_busy", clr_busy, 1);
    chk("abort_pre_r4", rdata0, 8'h44);
    rst = 1;
    #1;
    chk("abort_busy", clr_busy, 0);
    chk("abort_r4", rdata0, 0);
    chk("abort_bz6", rbusy1, 0);
    #1;
    rst = 0;
    done_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (clr_done) done_n++;
    end
    chk("abort_no_done", done_n, 0);
    read_all_zero("after_abort");

    @(negedge clk);
    idle_in();
    clr_req = 1;
    @(negedge clk);
    idle_in();
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 20 && done_n == 0; c++) begin
      #1;
      if (clr_busy) busy_n++;
      if (clr_done) done_n++;
      if (done_n == 0) @(negedge clk);
    end
    chk("rerun_busy_cycles", busy_n, 7);
    chk("rerun_done_seen", done_n, 1);

    // Writeback to a pending register while it is being read.
    wr(4, 8'h33);
    @(negedge clk);
    idle_in();
    iss_en = 1; iss_addr = 4;
    @(negedge clk);
    idle_in();
    we = 1; waddr = 4; wdata = 8'hA5;
    raddr0 = 0; raddr1 = 4;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp_rd1", rdata1, 8'hA5);
    chk("byp_bz1", rbusy1, 0);
`else
    chk("byp_rd1", rdata1, 8'h33);
    chk("byp_bz1", rbusy1, 1);
`endif
    @(negedge clk);
    idle_in();
    #1;
    chk("byp_next_rd1", rdata1, 8'hA5);
    chk("byp_next_bz1", rbusy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised successor to the 8x8 CPU register file: 2 async read ports, 1 write port, register 0 hardwired to zero.
- Adds a per-register pending scoreboard, set on instruction issue and cleared on writeback, so decode can stall on RAW/WAW hazards.
- Adds a multi-cycle soft-clear sequencer that zeroes the file without asserting global reset.
- Sits between decode/issue (scoreboard, read ports) and writeback (write port).

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers, DEPTH >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  writeback enable.
- waddr  in  ADDR_W  writeback register index.
- wdata  in  DATA_W  writeback data.
- raddr0  in  ADDR_W  read port 0 index.
- raddr1  in  ADDR_W  read port 1 index.
- rdata0  out  DATA_W  read port 0 data, combinational.
- rdata1  out  DATA_W  read port 1 data, combinational.
- rbusy0  out  1  pending bit of raddr0, combinational.
- rbusy1  out  1  pending bit of raddr1, combinational.
- iss_en  in  1  issue request: mark iss_addr pending.
- iss_addr  in  ADDR_W  destination of issuing instruction.
- iss_rdy  out  1  issue accepted this cycle, combinational.
- clr_req  in  1  start soft clear.
- clr_busy  out  1  soft clear in progress.
- clr_done  out  1  one-cycle pulse when soft clear completes.

Behaviour:
- Reset (async, any state, including mid-clear):
  - all registers and pending bits go to 0; FSM goes to IDLE; clr_busy=0, clr_done=0.
  - a clear in progress is aborted; the result is still an all-zero file.
- Register 0:
  - reads return 0 with busy=0.
  - writes and issues to it are dropped; its pending bit is never set.
- Reads: rdataN = reg[raddrN], rbusyN = pending[raddrN]; purely combinational, valid in every state including CLEAR.
- Write, valid when we && waddr!=0 && !clr_busy:
  - at posedge, reg[waddr] <= wdata and pending[waddr] <= 0.
  - in every other case the write is silently dropped.
- iss_rdy = iss_addr!=0 && !pending[iss_addr] && !clr_busy.
  - iss_addr=0 gives iss_rdy=0. No pending state is created, and issue logic must treat r0 destinations as not needing the scoreboard.
  - issue takes effect when iss_en && iss_rdy: pending[iss_addr] <= 1 at posedge.
  - iss_en && !iss_rdy: ignored, no state change (WAW stall).
- Simultaneous valid write and valid issue to the same address: pending ends at 1 (issue wins) and data is written.
  - This requires the pending bit to be 0 beforehand, which it is, since issue needs it clear.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 at posedge -> CLEAR with idx=1. Writes and issues in that same cycle are still accepted.
  - CLEAR: clr_busy=1. Each posedge does reg[idx] <= 0, pending[idx] <= 0, idx <= idx+1. When idx==DEPTH-1 the next state is DONE. Total DEPTH-1 cycles in CLEAR. clr_req is ignored.
  - DONE: clr_busy=0, clr_done=1 for exactly one cycle, then IDLE. Writes and issues are accepted. clr_req in DONE is ignored.
- Latency: clr_req seen at edge E, clr_busy high for edges E+1..E+DEPTH-1, clr_done high in the cycle after edge E+DEPTH-1.
- Width rules: idx is ADDR_W bits and does not wrap past DEPTH-1. All comparisons are unsigned.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - when a valid write (we && waddr!=0 && !clr_busy) matches raddrN, rdataN = wdata and rbusyN = 0 in the same cycle (write-to-read forwarding).
  - port 0 and port 1 bypass independently.
- Undefined: reads see the old value and pending bit until the following cycle.

Test Plan:
- Reset, then read all 8 addresses -> every rdata = 0x00 and every rbusy = 0. Write we=1, waddr=0, wdata=0xFF -> raddr0=0 still reads 0x00.
- Issue to r3, then read raddr0=3 -> rbusy0=1; a second issue to r3 gives iss_rdy=0 with no change. Writeback r3=0x5A next cycle -> rbusy0=0, rdata0=0x5A.
- In the same cycle, write r5=0x11 and issue r5 (pending 0) -> after the edge rdata=0x11 and rbusy=1.
- Load r1..r7 with 0x10..0x70, then pulse clr_req -> clr_busy high for 7 cycles, clr_done pulses once, then all reads return 0. A write to r2 and an issue mid-clear are both dropped (iss_rdy=0).
- Assert rst on the 3rd CLEAR cycle -> immediately all zero, FSM in IDLE, clr_done never pulses. A new clr_req afterwards runs the full 7 cycles.
- With RF_BYPASS_EN, write r4=0xA5 while raddr1=4 and r4 is pending -> rdata1=0xA5, rbusy1=0 in the same cycle. Without the macro, the old value and rbusy1=1 are shown until the next cycle.
